// File: rtl/rat_pc_pkg.sv
// Shared types and helpers for the RAT program counter with return-address stack.
package rat_pc_pkg;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_RAS   = 2'd3
    } pc_sel_t;

    localparam int PC_MAX_W = 32;

    // Increment that wraps modulo 2**width; callers truncate to their own width.
    function automatic logic [PC_MAX_W-1:0] pc_inc(input logic [PC_MAX_W-1:0] addr,
                                                   input int unsigned         width);
        logic [PC_MAX_W-1:0] mask;
        if (width >= PC_MAX_W) begin
            mask = {PC_MAX_W{1'b1}};
        end else begin
            mask = (PC_MAX_W'(1) << width) - PC_MAX_W'(1);
        end
        return (addr + PC_MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/prog_counter_rs_if.sv
// Control/status bundle between the control unit (master) and the program counter (slave).
interface prog_counter_rs_if #(
    parameter int ADDR_W = 10
);
    logic              PC_LD;
    logic              PC_INC;
    logic [1:0]        PC_MUX_SEL;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] FROM_STACK;
    logic              CALL;
    logic              RET;
    logic [ADDR_W-1:0] PC_COUNT;
    logic [ADDR_W-1:0] RS_TOP;
    logic              RS_EMPTY;
    logic              RS_FULL;
    logic              RS_ERR;

    modport master (
        output PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK, CALL, RET,
        input  PC_COUNT, RS_TOP, RS_EMPTY, RS_FULL, RS_ERR
    );

    modport slave (
        input  PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK, CALL, RET,
        output PC_COUNT, RS_TOP, RS_EMPTY, RS_FULL, RS_ERR
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Hardware return-address LIFO with registered top/flags and a sticky error flag.
// Build option PC_RS_CIRCULAR_EN: push-when-full overwrites the oldest entry.
module ret_addr_stack #(
    parameter int ADDR_W   = 10,
    parameter int RS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              err_set,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              err
);
    localparam int PW = $clog2(RS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] P_ONE_C = PW'(1);
    localparam logic [PW-1:0] P_TWO_C = PW'(2);

    logic [ADDR_W-1:0] mem_r [RS_DEPTH];
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [ADDR_W-1:0] top_r;
    logic [ADDR_W-1:0] top_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic              do_push_s;
    logic              do_pop_s;
    logic              empty_s;
    logic              full_s;
    logic [PW-1:0]     ptr_s;

`ifdef PC_RS_CIRCULAR_EN
    logic [PW-1:0]     wp_r;
    assign ptr_s = wp_r;
`else
    // Without wrap-around the next free slot is simply the entry count.
    assign ptr_s = count_r[PW-1:0];
`endif

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == DEPTH_C);

    // Push/pop decision, next count, next top and error accumulation.
    always_comb begin
        do_push_s   = 1'b0;
        do_pop_s    = 1'b0;
        count_nxt_s = count_r;
        top_nxt_s   = top_r;
        err_nxt_s   = err_r | err_set;
        if (push && pop) begin
            err_nxt_s = 1'b1;
        end else if (push) begin
            if (full_s) begin
`ifdef PC_RS_CIRCULAR_EN
                do_push_s = 1'b1;
`else
                err_nxt_s = 1'b1;
`endif
            end else begin
                do_push_s   = 1'b1;
                count_nxt_s = count_r + ONE_C;
            end
        end else if (pop) begin
            if (empty_s) begin
                err_nxt_s = 1'b1;
            end else begin
                do_pop_s    = 1'b1;
                count_nxt_s = count_r - ONE_C;
            end
        end else begin
            count_nxt_s = count_r;
        end

        if (do_push_s) begin
            top_nxt_s = din;
        end else if (do_pop_s) begin
            top_nxt_s = (count_r > ONE_C) ? mem_r[ptr_s - P_TWO_C] : {ADDR_W{1'b0}};
        end else begin
            top_nxt_s = top_r;
        end
    end

    // Count, top, error (and ring pointer) registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            top_r   <= {ADDR_W{1'b0}};
            err_r   <= 1'b0;
`ifdef PC_RS_CIRCULAR_EN
            wp_r    <= {PW{1'b0}};
`endif
        end else begin
            count_r <= count_nxt_s;
            top_r   <= top_nxt_s;
            err_r   <= err_nxt_s;
`ifdef PC_RS_CIRCULAR_EN
            if (do_push_s) begin
                wp_r <= wp_r + P_ONE_C;
            end else if (do_pop_s) begin
                wp_r <= wp_r - P_ONE_C;
            end
`endif
        end
    end

    // Storage is not reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (!rst && do_push_s) begin
            mem_r[ptr_s] <= din;
        end
    end

    assign top   = top_r;
    assign empty = empty_s;
    assign full  = full_s;
    assign err   = err_r;

endmodule

// File: rtl/prog_counter_rs.sv
// RAT MCU program counter: legacy load/increment mux plus CALL/RET through a return-address stack.
// Build option PC_RS_CIRCULAR_EN selects a circular return stack (see ret_addr_stack).
module prog_counter_rs
    import rat_pc_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                RS_DEPTH   = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] INTR_VEC   = {ADDR_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               RST,
    prog_counter_rs_if.slave   bus
);
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pc_plus1_s;
    logic [ADDR_W-1:0] mux_s;
    logic [ADDR_W-1:0] rs_top_s;
    logic              rs_empty_s;
    logic              rs_full_s;
    logic              rs_err_s;
    logic              sel_err_s;

    assign pc_plus1_s = ADDR_W'(pc_inc(PC_MAX_W'(pc_r), ADDR_W));

    // Legacy load-source mux; the RAS top reads as zero when the stack is empty.
    always_comb begin
        mux_s = bus.FROM_IMMED;
        case (pc_sel_t'(bus.PC_MUX_SEL))
            SEL_IMMED: mux_s = bus.FROM_IMMED;
            SEL_STACK: mux_s = bus.FROM_STACK;
            SEL_INTR:  mux_s = INTR_VEC;
            SEL_RAS:   mux_s = rs_top_s;
            default:   mux_s = bus.FROM_IMMED;
        endcase
    end

    // Per-cycle priority: CALL/RET over PC_LD over PC_INC over hold.
    always_comb begin
        pc_nxt_s  = pc_r;
        sel_err_s = 1'b0;
        if (bus.CALL && bus.RET) begin
            pc_nxt_s = pc_r;
        end else if (bus.CALL) begin
            pc_nxt_s = bus.FROM_IMMED;
        end else if (bus.RET) begin
            pc_nxt_s = rs_empty_s ? pc_r : rs_top_s;
        end else if (bus.PC_LD) begin
            pc_nxt_s  = mux_s;
            sel_err_s = (pc_sel_t'(bus.PC_MUX_SEL) == SEL_RAS) && rs_empty_s;
        end else if (bus.PC_INC) begin
            pc_nxt_s = pc_plus1_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r <= RESET_ADDR;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    ret_addr_stack #(
        .ADDR_W   (ADDR_W),
        .RS_DEPTH (RS_DEPTH)
    ) u_ras (
        .clk     (CLK),
        .rst     (RST),
        .push    (bus.CALL),
        .pop     (bus.RET),
        .err_set (sel_err_s),
        .din     (pc_plus1_s),
        .top     (rs_top_s),
        .empty   (rs_empty_s),
        .full    (rs_full_s),
        .err     (rs_err_s)
    );

    assign bus.PC_COUNT = pc_r;
    assign bus.RS_TOP   = rs_top_s;
    assign bus.RS_EMPTY = rs_empty_s;
    assign bus.RS_FULL  = rs_full_s;
    assign bus.RS_ERR   = rs_err_s;

endmodule

// File: tb/tb_prog_counter_rs.sv
// Self-checking bench for prog_counter_rs: directed scenarios plus random traffic vs. a queue model.
module tb_prog_counter_rs;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int AMOD  = 1 << AW;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // Reference model state
    int   m_pc;
    int   m_stk[$];
    bit   m_err;

    prog_counter_rs_if #(.ADDR_W(AW)) bus ();

    prog_counter_rs #(
        .ADDR_W   (AW),
        .RS_DEPTH (DEPTH)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (bus.CALL && bus.RET) begin
            m_err = 1'b1;
        end else if (bus.CALL) begin
            if (m_stk.size() == DEPTH) begin
`ifdef PC_RS_CIRCULAR_EN
                void'(m_stk.pop_front());
                m_stk.push_back((m_pc + 1) % AMOD);
`else
                m_err = 1'b1;
`endif
            end else begin
                m_stk.push_back((m_pc + 1) % AMOD);
            end
            m_pc = int'(bus.FROM_IMMED);
        end else if (bus.RET) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (bus.PC_LD) begin
            case (bus.PC_MUX_SEL)
                2'd0: m_pc = int'(bus.FROM_IMMED);
                2'd1: m_pc = int'(bus.FROM_STACK);
                2'd2: m_pc = AMOD - 1;
                default: begin
                    if (m_stk.size() == 0) begin
                        m_pc  = 0;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_stk[m_stk.size() - 1];
                    end
                end
            endcase
        end else if (bus.PC_INC) begin
            m_pc = (m_pc + 1) % AMOD;
        end
    endtask

    task automatic check_all(input string tag);
        int top;
        top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1];
        check_val({tag, ".pc"},    32'(bus.PC_COUNT), 32'(m_pc));
        check_val({tag, ".top"},   32'(bus.RS_TOP),   32'(top));
        check_val({tag, ".empty"}, 32'(bus.RS_EMPTY), 32'(m_stk.size() == 0));
        check_val({tag, ".full"},  32'(bus.RS_FULL),  32'(m_stk.size() == DEPTH));
        check_val({tag, ".err"},   32'(bus.RS_ERR),   32'(m_err));
    endtask

    // Apply one cycle of controls, advance the model at the edge, check just after it.
    task automatic cyc(input string tag, input bit r, input bit call, input bit ret,
                       input bit ld, input bit inc, input logic [1:0] sel,
                       input logic [AW-1:0] imm, input logic [AW-1:0] fstk);
        rst            = r;
        bus.CALL       = call;
        bus.RET        = ret;
        bus.PC_LD      = ld;
        bus.PC_INC     = inc;
        bus.PC_MUX_SEL = sel;
        bus.FROM_IMMED = imm;
        bus.FROM_STACK = fstk;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_rst();  cyc("rst", 1, 0, 0, 0, 0, 2'd0, '0, '0); endtask
    task automatic do_inc();  cyc("inc", 0, 0, 0, 0, 1, 2'd0, '0, '0); endtask
    task automatic do_ret();  cyc("ret", 0, 0, 1, 0, 0, 2'd0, '0, '0); endtask
    task automatic do_call(input logic [AW-1:0] t); cyc("call", 0, 1, 0, 0, 0, 2'd0, t, '0); endtask
    task automatic do_ld(input logic [1:0] s, input logic [AW-1:0] imm, input logic [AW-1:0] fs);
        cyc("ld", 0, 0, 0, 1, 0, s, imm, fs);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pc  = 0;
        m_err = 1'b0;
        rst = 1'b1;
        bus.CALL = 1'b0; bus.RET = 1'b0; bus.PC_LD = 1'b0; bus.PC_INC = 1'b0;
        bus.PC_MUX_SEL = 2'd0; bus.FROM_IMMED = '0; bus.FROM_STACK = '0;

        // Reset then count up
        do_rst();
        check_val("reset_pc", 32'(bus.PC_COUNT), 32'h0);
        for (int i = 0; i < 5; i++) do_inc();
        check_val("inc5_pc", 32'(bus.PC_COUNT), 32'h5);

        // Nested CALL/RET
        do_ld(2'd0, 10'h010, '0);
        do_call(10'h100);
        check_val("call1_top", 32'(bus.RS_TOP), 32'h011);
        do_call(10'h200);
        check_val("call2_top", 32'(bus.RS_TOP), 32'h101);
        do_ret();
        check_val("ret1_pc", 32'(bus.PC_COUNT), 32'h101);
        do_ret();
        check_val("ret2_pc", 32'(bus.PC_COUNT), 32'h011);
        check_val("ret2_empty", 32'(bus.RS_EMPTY), 32'h1);

        // Fill and overflow
        do_ld(2'd0, 10'h000, '0);
        for (int i = 0; i < 9; i++) do_call(10'h050);
        check_val("ovf_full", 32'(bus.RS_FULL), 32'h1);
`ifdef PC_RS_CIRCULAR_EN
        check_val("ovf_err", 32'(bus.RS_ERR), 32'h0);
        for (int i = 0; i < 8; i++) begin
            do_ret();
            check_val("circ_ret_pc", 32'(bus.PC_COUNT), 32'h051);
        end
`else
        check_val("ovf_err", 32'(bus.RS_ERR), 32'h1);
`endif

        // RET on empty, then reset clears error
        do_rst();
        do_ld(2'd0, 10'h020, '0);
        do_ret();
        check_val("ret_empty_pc", 32'(bus.PC_COUNT), 32'h020);
        check_val("ret_empty_err", 32'(bus.RS_ERR), 32'h1);
        do_rst();
        check_val("rst_err", 32'(bus.RS_ERR), 32'h0);

        // Wrap, interrupt vector, LD beats INC, CALL from top address
        do_ld(2'd0, 10'h3FF, '0);
        do_inc();
        check_val("wrap_pc", 32'(bus.PC_COUNT), 32'h000);
        do_ld(2'd2, '0, '0);
        check_val("intr_pc", 32'(bus.PC_COUNT), 32'h3FF);
        cyc("ld_inc", 0, 0, 0, 1, 1, 2'd1, 10'h155, 10'h2AA);
        check_val("ld_inc_pc", 32'(bus.PC_COUNT), 32'h2AA);
        do_ld(2'd0, 10'h3FF, '0);
        do_call(10'h040);
        check_val("call_wrap_top", 32'(bus.RS_TOP), 32'h000);
        do_ld(2'd3, '0, '0);
        check_val("sel3_pc", 32'(bus.PC_COUNT), 32'h000);
        do_ret();
        do_ld(2'd3, 10'h123, '0);
        check_val("sel3_empty_err", 32'(bus.RS_ERR), 32'h1);

        // CALL+RET together, then reset right after a CALL
        do_rst();
        do_call(10'h030);
        cyc("call_ret", 0, 1, 1, 1, 1, 2'd0, 10'h0AB, '0);
        check_val("call_ret_pc", 32'(bus.PC_COUNT), 32'h030);
        check_val("call_ret_err", 32'(bus.RS_ERR), 32'h1);
        do_call(10'h111);
        do_rst();
        check_val("rst_after_call_empty", 32'(bus.RS_EMPTY), 32'h1);
        check_val("rst_after_call_pc", 32'(bus.PC_COUNT), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc("rnd",
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0),
                2'($urandom_range(0, 3)),
                AW'($urandom_range(0, AMOD - 1)),
                AW'($urandom_range(0, AMOD - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
